// File: rtl/pl_prefix_engine.sv
// pl_prefix_engine
//   PL-side compute engine behind the PS/PL memory arbiter. Once the arbiter
//   grants the memory port, the engine reads a length word and a source
//   vector, writes the running (prefix) sum of the vector back to memory,
//   writes a status word and then raises finish_pl so that PS can take the
//   port back.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-low reset
//   launch_pl    in   memory port granted to PL
//   ready_for_pl in   PS request level; dropping it releases DONE
//   mem_dout     in   [31:0] read data, valid one cycle after the address
//   we_pl        out  memory write enable (one cycle per write)
//   address_pl   out  [7:0] memory address
//   data_in_pl   out  [31:0] memory write data
//   finish_pl    out  computation complete, held until ready_for_pl drops
//   busy         out  high in every state except IDLE and DONE
//
// Every output is a register loaded from the value it must have in the
// state being entered, so the outputs are Moore and have no combinational
// path from any input.
module pl_prefix_engine #(
  parameter logic [7:0] CFG_ADDR  = 8'd0,
  parameter logic [7:0] SRC_BASE  = 8'd1,
  parameter logic [7:0] DST_BASE  = 8'd128,
  parameter logic [7:0] STAT_ADDR = 8'd255,
  parameter int         MAX_LEN   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        launch_pl,
  input  logic        ready_for_pl,
  input  logic [31:0] mem_dout,
  output logic        we_pl,
  output logic [7:0]  address_pl,
  output logic [31:0] data_in_pl,
  output logic        finish_pl,
  output logic        busy
);

  localparam logic [7:0] MAX_LEN8 = MAX_LEN[7:0];

  typedef enum logic [2:0] {
    IDLE, CFG_RD, CFG_WAIT, RD, RD_WAIT, WR, STAT_WR, DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] acc_reg, acc_next;
  logic [7:0]  idx_reg, idx_next;
  logic [7:0]  n_reg, n_next;
  logic        clamp_reg, clamp_next;
  logic        ovf_reg, ovf_next;

  logic        we_next;
  logic [7:0]  address_next;
  logic [31:0] data_next;
  logic        finish_next;
  logic        busy_next;

  logic [32:0] sum;
  logic        active;

  // 33-bit sum so the carry out of the accumulator is visible.
  assign sum = {1'b0, acc_reg} + {1'b0, mem_dout};

  // States in which losing the grant aborts the run.
  assign active = (state_reg != IDLE) && (state_reg != DONE);

  // Next-state and datapath updates.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    idx_next   = idx_reg;
    n_next     = n_reg;
    clamp_next = clamp_reg;
    ovf_next   = ovf_reg;

    if (active && !launch_pl) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (launch_pl) begin
            state_next = CFG_RD;
            acc_next   = '0;
            idx_next   = '0;
            clamp_next = 1'b0;
            ovf_next   = 1'b0;
          end
        end
        CFG_RD: state_next = CFG_WAIT;
        CFG_WAIT: begin
          if (mem_dout[7:0] > MAX_LEN8) begin
            n_next     = MAX_LEN8;
            clamp_next = 1'b1;
          end else begin
            n_next = mem_dout[7:0];
          end
          state_next = (n_next != 8'd0) ? RD : STAT_WR;
        end
        RD: state_next = RD_WAIT;
        RD_WAIT: begin
          acc_next = sum[31:0];
          if (sum[32]) ovf_next = 1'b1;
          state_next = WR;
        end
        WR: begin
          idx_next   = idx_reg + 8'd1;
          state_next = ((idx_reg + 8'd1) < n_reg) ? RD : STAT_WR;
        end
        STAT_WR: state_next = DONE;
        DONE: begin
          if (!ready_for_pl) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output values for the state being entered; address and data hold
  // their previous value in states that do not drive them.
  always_comb begin
    we_next      = (state_next == WR) || (state_next == STAT_WR);
    finish_next  = (state_next == DONE);
    busy_next    = (state_next != IDLE) && (state_next != DONE);
    address_next = address_pl;
    data_next    = data_in_pl;
    case (state_next)
      CFG_RD:  address_next = CFG_ADDR;
      RD:      address_next = SRC_BASE + idx_next;
      WR: begin
        address_next = DST_BASE + idx_next;
        data_next    = acc_next;
      end
      STAT_WR: begin
        address_next = STAT_ADDR;
        data_next    = {clamp_next, ovf_next, 22'b0, n_next};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      idx_reg    <= '0;
      n_reg      <= '0;
      clamp_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      we_pl      <= 1'b0;
      address_pl <= '0;
      data_in_pl <= '0;
      finish_pl  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      idx_reg    <= idx_next;
      n_reg      <= n_next;
      clamp_reg  <= clamp_next;
      ovf_reg    <= ovf_next;
      we_pl      <= we_next;
      address_pl <= address_next;
      data_in_pl <= data_next;
      finish_pl  <= finish_next;
      busy       <= busy_next;
    end
  end

endmodule
